// File: rtl/rr_request_arbiter.sv
// Round-robin request arbiter feeding the 16-to-4 encoder: sticky pending capture,
// registered one-hot grant held until acknowledged, saturating coalesce counter.
module rr_request_arbiter #(
    parameter int N_REQ = 16,
    parameter int PTR_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:15]      req_in,
    input  logic [0:15]      mask,
    input  logic             grant_ack,
    output logic [0:15]      grant,
    output logic             grant_valid,
    output logic [0:15]      pending,
    output logic [CNT_W-1:0] coalesce_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [PTR_W-1:0]   grant_idx, grant_idx_next;
    logic [0:15]        grant_next;
    logic               grant_valid_next;
    logic [0:15]        clr;
    logic [0:15]        pending_next;
    logic [0:15]        eligible;
    logic [0:15]        merged;
    logic [4:0]         merged_cnt;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   coalesce_next;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;

    assign eligible = pending & ~mask;

    // Round-robin scan starting at ptr; first eligible line wins.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            logic [PTR_W-1:0] idx;
            idx = ptr + PTR_W'(i);
            if (!pick_found && eligible[idx]) begin
                pick_idx   = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        grant_idx_next   = grant_idx;
        grant_next       = grant;
        grant_valid_next = grant_valid;
        clr              = '0;
        case (state)
            IDLE: begin
                grant_next       = '0;
                grant_valid_next = 1'b0;
                if (pick_found) begin
                    grant_next[pick_idx] = 1'b1;
                    grant_valid_next     = 1'b1;
                    grant_idx_next       = pick_idx;
                    state_next           = GRANT;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    clr              = grant;
                    ptr_next         = grant_idx + 1'b1;
                    grant_next       = '0;
                    grant_valid_next = 1'b0;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A request arriving with the clearing ack re-arms the bit rather than coalescing.
    always_comb begin
        pending_next = (pending & ~clr) | req_in;
        merged       = req_in & pending & ~clr;
        merged_cnt   = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            merged_cnt = merged_cnt + {4'b0, merged[k]};
        end
        cnt_sum = {1'b0, coalesce_cnt} + (CNT_W+1)'(merged_cnt);
        if (cnt_sum[CNT_W]) begin
            coalesce_next = '1;
        end else begin
            coalesce_next = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_idx    <= '0;
            grant        <= '0;
            grant_valid  <= 1'b0;
            pending      <= '0;
            coalesce_cnt <= '0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            grant_idx    <= grant_idx_next;
            grant        <= grant_next;
            grant_valid  <= grant_valid_next;
            pending      <= pending_next;
            coalesce_cnt <= coalesce_next;
        end
    end

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed self-checking bench for rr_request_arbiter.
module tb_rr_request_arbiter;

    logic        clk;
    logic        reset;
    logic [0:15] req_in;
    logic [0:15] mask;
    logic        grant_ack;
    logic [0:15] grant;
    logic        grant_valid;
    logic [0:15] pending;
    logic [7:0]  coalesce_cnt;

    int unsigned checks;
    int unsigned errors;

    rr_request_arbiter #(
        .N_REQ(16),
        .PTR_W(4),
        .CNT_W(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .mask        (mask),
        .grant_ack   (grant_ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .pending     (pending),
        .coalesce_cnt(coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:15] line(input int unsigned k);
        logic [0:15] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        req_in    = '0;
        mask      = '0;
        grant_ack = 1'b0;

        // 1: single request on line 15
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_cnt", 32'(coalesce_cnt), 32'h0);
        req_in = 16'b0000000000000001;
        tick();
        req_in = '0;
        check("t1_pending", 32'(pending), 32'h0001);
        check("t1_valid_early", 32'(grant_valid), 32'h0);
        tick();
        check("t1_valid", 32'(grant_valid), 32'h1);
        check("t1_grant", 32'(grant), 32'h0001);
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check("t1_valid_after_ack", 32'(grant_valid), 32'h0);
        check("t1_pending_after_ack", 32'(pending), 32'h0);
        check("t1_cnt", 32'(coalesce_cnt), 32'h0);

        // 2: all 16 lines together, served in index order
        do_reset();
        req_in = 16'hFFFF;
        tick();
        req_in = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("t2_grant%0d", i), 32'(grant), 32'(line(i)));
            check($sformatf("t2_valid%0d", i), 32'(grant_valid), 32'h1);
            grant_ack = 1'b1;
            tick();
            grant_ack = 1'b0;
            check($sformatf("t2_gap%0d", i), 32'(grant_valid), 32'h0);
        end
        check("t2_pending_end", 32'(pending), 32'h0);

        // 3: pointer after line 2 is 3, so line 0 wins via wrap, then line 2
        do_reset();
        req_in = line(2);
        tick();
        req_in = '0;
        tick();
        check("t3_first", 32'(grant), 32'(line(2)));
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        req_in = line(0) | line(2);
        tick();
        req_in = '0;
        tick();
        check("t3_wrap", 32'(grant), 32'(line(0)));
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        tick();
        check("t3_next", 32'(grant), 32'(line(2)));
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;

        // 4: held grant on line 5 with mask toggling and repeated requests
        do_reset();
        req_in = line(5);
        tick();
        req_in = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            mask[5] = c[0];
            req_in  = (c == 1 || c == 4 || c == 7) ? line(5) : '0;
            tick();
            check($sformatf("t4_hold%0d", c), 32'(grant), 32'(line(5)));
        end
        req_in = '0;
        mask   = '0;
        check("t4_cnt", 32'(coalesce_cnt), 32'd3);
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check("t4_pending", 32'(pending), 32'h0);

        // 5: ack coinciding with a new request on the same line
        do_reset();
        req_in = line(7);
        tick();
        req_in = '0;
        tick();
        check("t5_grant", 32'(grant), 32'(line(7)));
        grant_ack = 1'b1;
        req_in    = line(7);
        tick();
        grant_ack = 1'b0;
        req_in    = '0;
        check("t5_pending_kept", 32'(pending), 32'(line(7)));
        check("t5_cnt", 32'(coalesce_cnt), 32'h0);
        tick();
        check("t5_regrant", 32'(grant), 32'(line(7)));
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check("t5_cnt2", 32'(coalesce_cnt), 32'h0);
        mask   = 16'hFFFF;
        req_in = line(3);
        tick();
        req_in = '0;
        tick();
        tick();
        check("t5_masked_valid", 32'(grant_valid), 32'h0);
        check("t5_masked_pending", 32'(pending), 32'(line(3)));
        mask = '0;
        tick();
        check("t5_unmasked", 32'(grant), 32'(line(3)));
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;

        // 6: coalesce saturation, then reset mid-grant
        do_reset();
        req_in = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 15) check("t6_cnt240", 32'(coalesce_cnt), 32'd240);
        end
        check("t6_sat", 32'(coalesce_cnt), 32'd255);
        check("t6_grant", 32'(grant), 32'(line(0)));
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        req_in = '0;
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_valid", 32'(grant_valid), 32'h0);
        check("t6_rst_pending", 32'(pending), 32'h0);
        check("t6_rst_cnt", 32'(coalesce_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (!reset && grant_valid && !$onehot(grant)) begin
            check("onehot", 32'(grant), 32'h0);
        end
        if (!reset && !grant_valid && grant != '0) begin
            check("zero_when_invalid", 32'(grant), 32'h0);
        end
    end

endmodule
